// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: DMCtrl encodings, FSM states, the latched
// request record and the access-legality helpers.
package dmem_pkg;

    localparam logic [2:0] CtrlSb = 3'b000;
    localparam logic [2:0] CtrlSh = 3'b001;
    localparam logic [2:0] CtrlW  = 3'b010;
    localparam logic [2:0] CtrlUb = 3'b100;
    localparam logic [2:0] CtrlUh = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  ctrl;
    } req_t;

    // Unsigned loads are read-only; any other code is never legal.
    function automatic logic ctrl_err(input req_t r);
        logic err;
        unique case (r.ctrl)
            CtrlSb, CtrlSh, CtrlW: err = 1'b0;
            CtrlUb, CtrlUh:        err = r.we;
            default:               err = 1'b1;
        endcase
        return err;
    endfunction

    // Widened to 33 bits so addresses near 2^32 cannot wrap back into range.
    function automatic logic range_err(input logic [31:0] addr, input int unsigned mem_bytes);
        return ({1'b0, addr} + 33'd3) >= {1'b0, mem_bytes};
    endfunction

    function automatic logic align_err(input req_t r);
        logic err;
        unique case (r.ctrl[1:0])
            2'b01:   err = r.addr[0];
            2'b10:   err = |r.addr[1:0];
            default: err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone request wins, a tie goes to the requester at ptr.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter running a fixed IDLE/ACCESS/RESP handshake per access.
// Optional DMEM_ARB_ALIGN_CHECK_EN adds misaligned halfword/word detection.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    input  logic [NREQ-1:0]      req_we,
    input  logic [3*NREQ-1:0]    req_ctrl,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic [NREQ-1:0]      rsp_err,
    output logic [31:0]          address,
    output logic [31:0]          DataWr,
    output logic                 DMWr,
    output logic [2:0]           DMCtrl,
    input  logic [31:0]          DataRd
);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    req_t        win_req;
    logic [1:0]  gnt;
    logic        owner_q, owner_d;
    logic        ptr_q, ptr_d;
    logic        err_q, err_d;
    logic        acc_err;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_hold_q, addr_hold_d;
    logic [31:0] wdata_hold_q, wdata_hold_d;
    logic [2:0]  ctrl_hold_q, ctrl_hold_d;
    logic [1:0]  owner_oh;

    rr_arb2 u_rr_arb2 (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        win_req.addr  = gnt[1] ? req_addr[63:32]  : req_addr[31:0];
        win_req.wdata = gnt[1] ? req_wdata[63:32] : req_wdata[31:0];
        win_req.we    = gnt[1] ? req_we[1]        : req_we[0];
        win_req.ctrl  = gnt[1] ? req_ctrl[5:3]    : req_ctrl[2:0];
    end

    always_comb begin
        acc_err = ctrl_err(req_q) | range_err(req_q.addr, MEM_BYTES);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        acc_err = acc_err | align_err(req_q);
`else
        acc_err = acc_err | 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (|gnt) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Datapath next-state: latch on acceptance, capture result at the end of ACCESS
    always_comb begin
        req_d        = req_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        addr_hold_d  = addr_hold_q;
        wdata_hold_d = wdata_hold_q;
        ctrl_hold_d  = ctrl_hold_q;
        if (state_q == StIdle && |gnt) begin
            req_d   = win_req;
            owner_d = gnt[1];
        end
        if (state_q == StAccess) begin
            ptr_d        = ~owner_q;
            err_d        = acc_err;
            rdata_d      = (!acc_err && !req_q.we) ? DataRd : 32'h0;
            addr_hold_d  = req_q.addr;
            wdata_hold_d = req_q.wdata;
            ctrl_hold_d  = req_q.ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q        <= '0;
            owner_q      <= 1'b0;
            ptr_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
            addr_hold_q  <= 32'h0;
            wdata_hold_q <= 32'h0;
            ctrl_hold_q  <= 3'b000;
        end else begin
            req_q        <= req_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            addr_hold_q  <= addr_hold_d;
            wdata_hold_q <= wdata_hold_d;
            ctrl_hold_q  <= ctrl_hold_d;
        end
    end

    // Outputs; DMWr decodes from the async-reset state so a reset drops it immediately
    always_comb begin
        owner_oh  = owner_q ? 2'b10 : 2'b01;
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = '0;
        rsp_rdata = rdata_q;
        address   = addr_hold_q;
        DataWr    = wdata_hold_q;
        DMCtrl    = ctrl_hold_q;
        DMWr      = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = gnt & {NREQ{rst_n}};
            end
            StAccess: begin
                address = req_q.addr;
                DataWr  = req_q.wdata;
                DMCtrl  = req_q.ctrl;
                DMWr    = req_q.we & ~acc_err;
            end
            StResp: begin
                rsp_valid = owner_oh;
                rsp_err   = err_q ? owner_oh : 2'b00;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single-requester accesses plus
// hand-written reset, contention and mid-access reset sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_we;
    logic [5:0]  req_ctrl;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd;

    logic [31:0] mem [64];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NREQ      (2),
        .MEM_BYTES (256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .address   (address),
        .DataWr    (DataWr),
        .DMWr      (DMWr),
        .DMCtrl    (DMCtrl),
        .DataRd    (DataRd)
    );

    assign DataRd = mem[address[7:2]];

    always @(posedge clk) begin
        if (DMWr) mem[address[7:2]] <= DataWr;
    end

    typedef struct packed {
        logic        who;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        logic [1:0] oh;
        oh = v.who ? 2'b10 : 2'b01;
        @(negedge clk);
        req_valid = oh;
        req_addr  = v.who ? {v.addr, 32'h0}  : {32'h0, v.addr};
        req_wdata = v.who ? {v.wdata, 32'h0} : {32'h0, v.wdata};
        req_we    = v.who ? {v.we, 1'b0}     : {1'b0, v.we};
        req_ctrl  = v.who ? {v.ctrl, 3'b000} : {3'b000, v.ctrl};
        #1;
        check($sformatf("v%0d.ready", n), 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid = 2'b00;
        check($sformatf("v%0d.acc_ready", n), 32'(req_ready), 32'h0);
        check($sformatf("v%0d.acc_rspv", n), 32'(rsp_valid), 32'h0);
        check($sformatf("v%0d.dmwr", n), 32'(DMWr), 32'(v.we & ~v.exp_err));
        check($sformatf("v%0d.addr", n), address, v.addr);
        check($sformatf("v%0d.dmctrl", n), 32'(DMCtrl), 32'(v.ctrl));
        check($sformatf("v%0d.datawr", n), DataWr, v.wdata);
        @(negedge clk);
        check($sformatf("v%0d.rspv", n), 32'(rsp_valid), 32'(oh));
        check($sformatf("v%0d.rsperr", n), 32'(rsp_err), v.exp_err ? 32'(oh) : 32'h0);
        check($sformatf("v%0d.rdata", n), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d.resp_dmwr", n), 32'(DMWr), 32'h0);
        check($sformatf("v%0d.addr_hold", n), address, v.addr);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        mem[4] <= 32'hDEADBEEF;

        vecs[0]  = '{1'b0, 32'h10, 32'h0, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 3'b010, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 32'h20, 32'h0, 1'b0, 3'b010, 32'hCAFEF00D, 1'b0};
        vecs[3]  = '{1'b1, 32'h20, 32'h55555555, 1'b1, 3'b100, 32'h0, 1'b1};
        vecs[4]  = '{1'b0, 32'h20, 32'h0, 1'b0, 3'b010, 32'hCAFEF00D, 1'b0};
        vecs[5]  = '{1'b0, 32'hFE, 32'h0, 1'b0, 3'b010, 32'h0, 1'b1};
        vecs[6]  = '{1'b1, 32'h00, 32'h0, 1'b0, 3'b011, 32'h0, 1'b1};
        vecs[7]  = '{1'b1, 32'h30, 32'h0, 1'b0, 3'b100, 32'h1000000C, 1'b0};
        vecs[9]  = '{1'b0, 32'hFC, 32'h0, 1'b0, 3'b000, 32'h1000003F, 1'b0};
        vecs[10] = '{1'b1, 32'hFD, 32'h0, 1'b0, 3'b000, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 32'h40, 32'h77777777, 1'b1, 3'b110, 32'h0, 1'b1};
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        vecs[8]  = '{1'b0, 32'h11, 32'h0, 1'b0, 3'b010, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 32'h13, 32'h0, 1'b0, 3'b001, 32'h0, 1'b1};
`else
        vecs[8]  = '{1'b0, 32'h11, 32'h0, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0};
        vecs[12] = '{1'b0, 32'h13, 32'h0, 1'b0, 3'b001, 32'hDEADBEEF, 1'b0};
`endif

        // Reset holds every output low even with requests pending
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_addr  = {32'h0000_0030, 32'h0000_0010};
        req_wdata = 64'h0;
        req_we    = 2'b00;
        req_ctrl  = {3'b010, 3'b010};
        #2;
        check("rst.ready", 32'(req_ready), 32'h0);
        check("rst.rspv", 32'(rsp_valid), 32'h0);
        check("rst.rsperr", 32'(rsp_err), 32'h0);
        check("rst.rdata", rsp_rdata, 32'h0);
        check("rst.addr", address, 32'h0);
        check("rst.datawr", DataWr, 32'h0);
        check("rst.dmwr", 32'(DMWr), 32'h0);
        check("rst.dmctrl", 32'(DMCtrl), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rst.ready2", 32'(req_ready), 32'h0);

        // Contention straight out of reset: CPU first, then strict alternation
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_oh;
            exp_oh = (k % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            check($sformatf("rr%0d.ready", k), 32'(req_ready), 32'(exp_oh));
            @(negedge clk);
            @(negedge clk);
            check($sformatf("rr%0d.rspv", k), 32'(rsp_valid), 32'(exp_oh));
            check($sformatf("rr%0d.rdata", k), rsp_rdata,
                  (k % 2 == 1) ? 32'h1000000C : 32'hDEADBEEF);
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Fresh reset, then the single-requester table
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);
        @(negedge clk);
        check("mem.0x20", mem[8], 32'hCAFEF00D);
        check("mem.0x40", mem[16], 32'h10000010);

        // Reset during the ACCESS cycle of a legal DMA write
        req_valid = 2'b10;
        req_addr  = {32'h0000_0040, 32'h0};
        req_wdata = {32'h1111_2222, 32'h0};
        req_we    = 2'b10;
        req_ctrl  = {3'b010, 3'b000};
        @(negedge clk);
        req_valid = 2'b00;
        check("abort.dmwr_before", 32'(DMWr), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.dmwr_async", 32'(DMWr), 32'h0);
        check("abort.rspv", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort.mem", mem[16], 32'h10000010);
        check("abort.rspv2", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("abort.rspv3", 32'(rsp_valid), 32'h0);
        req_valid = 2'b11;
        req_we    = 2'b00;
        #1;
        check("abort.next_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning the number of requesters (fixed at 2 for this revision).
REQ-002 SHALL have parameter MEM_BYTES, default 256, meaning the addressable byte range of the attached data memory.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 2 bits: per-requester request valid (bit 0 = CPU, bit 1 = DMA/debug).
REQ-006 SHALL have port req_ready, output, 2 bits: per-requester accept strobe.
REQ-007 SHALL have port req_addr, input, 64 bits: byte address, 32 bits per requester.
REQ-008 SHALL have port req_wdata, input, 64 bits: write data, 32 bits per requester.
REQ-009 SHALL have port req_we, input, 2 bits: 1 = write, 0 = read.
REQ-010 SHALL have port req_ctrl, input, 6 bits: 3-bit size/sign code per requester (000 sb, 001 sh, 010 w, 100 ub, 101 uh).
REQ-011 SHALL have port rsp_valid, output, 2 bits: one-cycle completion pulse to the owning requester.
REQ-012 SHALL have port rsp_rdata, output, 32 bits: read data, shared and qualified by rsp_valid.
REQ-013 SHALL have port rsp_err, output, 2 bits: error flag, qualified by rsp_valid.
REQ-014 SHALL have memory-side outputs address (32 bits), DataWr (32 bits), DMWr (1 bit) and DMCtrl (3 bits), and memory-side input DataRd (32 bits).

Function
- REQ-015 SHALL implement FSM states IDLE, ACCESS and RESP, with transitions IDLE->ACCESS on acceptance, ACCESS->RESP always, and RESP->IDLE always; each access therefore takes 3 cycles.
- REQ-016 In IDLE with any req_valid set, SHALL pulse req_ready of exactly one winner that cycle and latch its addr/wdata/we/ctrl into a request register.
- REQ-017 A single valid requester SHALL win; with both valid, the round-robin pointer SHALL pick the winner, and the pointer SHALL move to the other requester when RESP is reached.
- REQ-018 In ACCESS, SHALL drive address, DataWr and DMCtrl from the request register and assert DMWr for exactly that one cycle when a legal write is in progress.
- REQ-019 Outside ACCESS, DMWr SHALL be 0, and address, DataWr and DMCtrl SHALL hold their last values.
- REQ-020 For a legal read, SHALL register DataRd at the end of ACCESS into rsp_rdata; for writes and errors, rsp_rdata SHALL be 0.
- REQ-021 In RESP, SHALL assert rsp_valid[owner] for exactly one cycle; req_ready SHALL be 0 in ACCESS and RESP.
- REQ-022 A write with ctrl outside {000,001,010}, or any access with ctrl in {011,110,111}, SHALL leave DMWr at 0 and complete with rsp_err=1.
- REQ-023 An access with address+3 >= MEM_BYTES SHALL not touch memory and SHALL complete with rsp_err=1.
- REQ-024 Requesters SHALL hold request fields stable while valid and not yet accepted; dropping valid before acceptance SHALL be legal and cancel the request.

Reset
- REQ-025 rst_n low SHALL immediately force the state to IDLE, the pointer to 0, and all outputs (req_ready, rsp_valid, rsp_rdata, rsp_err, address, DataWr, DMWr, DMCtrl) to 0.
- REQ-026 A reset asserted mid-ACCESS SHALL abort the access with no response, and DMWr SHALL fall asynchronously.

Configuration
- REQ-027 With DMEM_ARB_ALIGN_CHECK_EN defined, a halfword access at an odd address or a word access with addr[1:0]!=0 SHALL not touch memory and SHALL complete with rsp_err=1.
- REQ-028 Without DMEM_ARB_ALIGN_CHECK_EN, misaligned accesses SHALL pass to memory unchanged and rsp_err SHALL reflect only REQ-022/023.

Structure
- REQ-029 Package dmem_pkg SHALL hold the DMCtrl encodings, the FSM state enum and the request struct (addr, wdata, we, ctrl).
- REQ-030 The two-way round-robin selector SHALL be the sub-module rr_arb2 (inputs req[1:0] and ptr; output one-hot gnt).

Verification
- REQ-031 CPU only: read, ctrl 010, addr 0x10, memory holds 0xDEADBEEF -> req_ready[0] in cycle 0, rsp_valid[0] in cycle 2, rsp_rdata=0xDEADBEEF, rsp_err=0.
- REQ-032 Both valid after reset -> CPU served first, DMA second; back-to-back repeat -> order alternates DMA, CPU.
- REQ-033 DMA write, ctrl 100, addr 0x20 -> DMWr never asserts, rsp_err[1]=1, memory at 0x20 unchanged.
- REQ-034 Word read at addr 254 (MEM_BYTES=256) -> rsp_err=1, rsp_rdata=0; with DMEM_ARB_ALIGN_CHECK_EN, a word at 0x11 -> rsp_err=1; without it -> data returned, rsp_err=0.
- REQ-035 rst_n low during ACCESS of a write -> DMWr=0 within the same cycle, no rsp_valid, next grant goes to CPU.
